// File: rtl/countdown_timer_12b.sv
// countdown_timer_12b: loadable down-counting timer with one-shot and auto-reload modes.
// Optional tick prescaler is compiled in by defining COUNTDOWN_PRESCALE_EN.
module countdown_timer_12b #(
  parameter int WIDTH    = 12,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             tick;

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int            PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler, prescaler_next;

  assign tick = enable && (prescaler == PRESCALE_LAST);
`else
  // Without the prescaler every enabled cycle is a tick; the PRESCALE term folds to 1.
  assign tick = enable && (PRESCALE >= 1);
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    tc_next     = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
    prescaler_next = prescaler;
`endif

    if (load) begin
      reload_next = b;
      count_next  = b;
      state_next  = IDLE;
`ifdef COUNTDOWN_PRESCALE_EN
      prescaler_next = '0;
`endif
    end else if (start && (state != RUN)) begin
      // A zero reload value would never reach terminal count, so the start is dropped.
      if (reload_reg != '0) begin
        count_next = reload_reg;
        state_next = RUN;
`ifdef COUNTDOWN_PRESCALE_EN
        prescaler_next = '0;
`endif
      end
    end else if (state == RUN) begin
`ifdef COUNTDOWN_PRESCALE_EN
      if (enable) begin
        prescaler_next = (prescaler == PRESCALE_LAST) ? '0 : prescaler + 1'b1;
      end
`endif
      if (tick) begin
        if (count == COUNT_ONE) begin
          tc_next = 1'b1;
          if (auto_reload) begin
            count_next = reload_reg;
          end else begin
            count_next = '0;
            state_next = DONE;
          end
        end else begin
          count_next = count - 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
      prescaler  <= '0;
`endif
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      tc         <= tc_next;
`ifdef COUNTDOWN_PRESCALE_EN
      prescaler  <= prescaler_next;
`endif
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_timer_12b.sv
// Scoreboard bench for countdown_timer_12b: the driver queues expected outputs per cycle,
// a monitor pops and compares them one time unit after each rising edge.
module tb_countdown_timer_12b;

  localparam int WIDTH = 12;
`ifdef COUNTDOWN_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic             clk = 1'b0;
  logic             reset, load, start, enable, auto_reload;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] count;
  logic             tc, busy, done;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  countdown_timer_12b #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .b           (b),
    .start       (start),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock of stimulus plus the outputs expected right after the following rising edge.
  task automatic cyc(input logic r, input logic ld, input logic [WIDTH-1:0] bv,
                     input logic st, input logic en, input logic ar,
                     input logic [WIDTH-1:0] ec, input logic etc, input logic eb,
                     input logic ed, input string tag);
    exp_t e;
    @(negedge clk);
    reset       = r;
    load        = ld;
    b           = bv;
    start       = st;
    enable      = en;
    auto_reload = ar;
    e.count = ec;
    e.tc    = etc;
    e.busy  = eb;
    e.done  = ed;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".count"}, 32'(count), 32'(e.count));
        check({e.tag, ".tc"},    32'(tc),    32'(e.tc));
        check({e.tag, ".busy"},  32'(busy),  32'(e.busy));
        check({e.tag, ".done"},  32'(done),  32'(e.done));
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    reset = 1'b1; load = 1'b0; b = '0; start = 1'b1; enable = 1'b1; auto_reload = 1'b0;

    // reset with start and enable high
    cyc(1, 0, 0, 1, 1, 0,  0, 0, 0, 0, "rst1");
    cyc(1, 0, 0, 1, 1, 0,  0, 0, 0, 0, "rst2");

    // one-shot, N=5
    cyc(0, 1, 5, 0, 1, 0,  5, 0, 0, 0, "os_load");
    cyc(0, 0, 0, 1, 1, 0,  5, 0, 1, 0, "os_start");
    cyc(0, 0, 0, 0, 1, 0,  4, 0, 1, 0, "os_4");
    cyc(0, 0, 0, 0, 1, 0,  3, 0, 1, 0, "os_3");
    cyc(0, 0, 0, 0, 1, 0,  2, 0, 1, 0, "os_2");
    cyc(0, 0, 0, 0, 1, 0,  1, 0, 1, 0, "os_1");
    cyc(0, 0, 0, 0, 1, 0,  0, 1, 0, 1, "os_tc");
    cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, "os_hold1");
    cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, "os_hold2");

    // restart from DONE, start ignored in RUN, load aborts the run
    cyc(0, 0, 0, 1, 1, 0,  5, 0, 1, 0, "restart");
    cyc(0, 0, 0, 1, 1, 0,  4, 0, 1, 0, "start_in_run");
    cyc(0, 1, 9, 0, 1, 0,  9, 0, 0, 0, "abort_load");
    cyc(0, 0, 0, 0, 1, 0,  9, 0, 0, 0, "idle_hold");

    // periodic, N=3, then drop auto_reload mid-run
    cyc(0, 1, 3, 0, 1, 1,  3, 0, 0, 0, "per_load");
    cyc(0, 0, 0, 1, 1, 1,  3, 0, 1, 0, "per_start");
    cyc(0, 0, 0, 0, 1, 1,  2, 0, 1, 0, "per_2a");
    cyc(0, 0, 0, 0, 1, 1,  1, 0, 1, 0, "per_1a");
    cyc(0, 0, 0, 0, 1, 1,  3, 1, 1, 0, "per_tc1");
    cyc(0, 0, 0, 0, 1, 1,  2, 0, 1, 0, "per_2b");
    cyc(0, 0, 0, 0, 1, 1,  1, 0, 1, 0, "per_1b");
    cyc(0, 0, 0, 0, 1, 1,  3, 1, 1, 0, "per_tc2");
    cyc(0, 0, 0, 0, 1, 1,  2, 0, 1, 0, "per_2c");
    cyc(0, 0, 0, 0, 1, 0,  1, 0, 1, 0, "ar_off_1");
    cyc(0, 0, 0, 0, 1, 0,  0, 1, 0, 1, "ar_off_tc");

    // pause at count 3 for two cycles
    cyc(0, 1, 5, 0, 1, 0,  5, 0, 0, 0, "pz_load");
    cyc(0, 0, 0, 1, 1, 0,  5, 0, 1, 0, "pz_start");
    cyc(0, 0, 0, 0, 1, 0,  4, 0, 1, 0, "pz_4");
    cyc(0, 0, 0, 0, 1, 0,  3, 0, 1, 0, "pz_3");
    cyc(0, 0, 0, 0, 0, 0,  3, 0, 1, 0, "pz_hold1");
    cyc(0, 0, 0, 0, 0, 0,  3, 0, 1, 0, "pz_hold2");
    cyc(0, 0, 0, 0, 1, 0,  2, 0, 1, 0, "pz_2");
    cyc(0, 0, 0, 0, 1, 0,  1, 0, 1, 0, "pz_1");
    cyc(0, 0, 0, 0, 1, 0,  0, 1, 0, 1, "pz_tc");

    // reset mid-run clears reload register too; zero reload blocks start
    cyc(0, 1, 7, 0, 1, 0,  7, 0, 0, 0, "rr_load");
    cyc(0, 0, 0, 1, 1, 0,  7, 0, 1, 0, "rr_start");
    cyc(0, 0, 0, 0, 1, 0,  6, 0, 1, 0, "rr_6");
    cyc(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, "rr_reset");
    cyc(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, "rr_start_zero");
    cyc(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, "z_load");
    cyc(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, "z_start");
    cyc(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, "z_idle");

    // full-scale load counts all the way down without wrapping
    cyc(0, 1, 12'hFFF, 0, 1, 0,  12'hFFF, 0, 0, 0, "max_load");
    cyc(0, 0, 0,       1, 1, 0,  12'hFFF, 0, 1, 0, "max_start");
    for (int k = 4094; k >= 0; k--) begin
      cyc(0, 0, 0, 0, 1, 0, WIDTH'(k), k == 0, k != 0, k == 0, "max_run");
    end

    // N=2: terminal count after 2*P enabled cycles
    cyc(0, 1, 2, 0, 1, 0,  2, 0, 0, 0, "ps_load");
    cyc(0, 0, 0, 1, 1, 0,  2, 0, 1, 0, "ps_start");
    for (int c = 1; c <= 2 * P; c++) begin
      cyc(0, 0, 0, 0, 1, 0, WIDTH'(2 - c / P), c == 2 * P, c < 2 * P, c == 2 * P, "ps_run");
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
